rf_dump_reader: RTL
===================

# rf_dump_reader

Read-side sequencer for the 2-read/1-write block-SRAM register file. On a `start` pulse it walks a contiguous register range through one RF read port (`p0_addr`/`re0`/`p0`) and streams each `{address, data}` pair out over a valid/ready handshake. It replaces the simulation-only halt dump with a synthesizable path toward a UART/debug sink. It sits beside the CPU's RF and owns the read port only while `busy` is high.

## Interface
Parameters:
- `ADDR_W`, default 4: RF address width.
- `DATA_W`, default 16: RF data width.
- `FIRST_REG`, default 1: first register dumped. R0 is hardwired zero and is skipped.
- `LAST_REG`, default 15: last register dumped. `FIRST_REG <= LAST_REG` is required.

Ports:
- `clk`  in  1  system clock. Posedge logic only. The RF updates its read data on negedge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle request to begin a dump. Ignored while `busy`.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse after the last word's handshake.
- `rf_addr`  out  ADDR_W  drives RF `p0_addr`.
- `rf_re`  out  1  drives RF `re0`.
- `rf_data`  in  DATA_W  from RF `p0`.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  sink accepts the word.
- `out_addr`  out  ADDR_W  register index of the current word.
- `out_data`  out  DATA_W  register contents of the current word.

## Operation
- FSM states: IDLE, READ, SEND. All outputs are registered.
- **Reset:** state IDLE. `busy`, `done`, `rf_re`, `out_valid` = 0. `rf_addr`, `out_addr`, `out_data` = 0.
- **IDLE:**
  - `start` = 1 → `rf_addr` <= `FIRST_REG`, `rf_re` <= 1, `busy` <= 1, go to READ.
  - Otherwise stay in IDLE.
- **READ** (exactly one cycle; the RF latches `p0` on the mid-cycle negedge):
  - `out_data` <= `rf_data`, `out_addr` <= `rf_addr`, `out_valid` <= 1, `rf_re` <= 0, go to SEND.
- **SEND:**
  - Hold `out_valid`, `out_addr` and `out_data` stable while `out_ready` = 0.
  - On `out_valid && out_ready` with `out_addr == LAST_REG` → `out_valid` <= 0, `busy` <= 0, `done` <= 1, go to IDLE.
  - On handshake otherwise → `out_valid` <= 0, `rf_addr` <= `rf_addr + 1`, `rf_re` <= 1, go to READ.
- `rf_re` is high only in READ cycles, which keeps the read-enable power contract. `rf_data` is sampled only at the READ→SEND edge, so the RF port may change freely at other times.
- `done` clears to 0 the cycle after it is set.
- `start` while `busy` is ignored. `start` coincident with the `done` cycle is accepted, because the FSM is already in IDLE.
- `rst` mid-dump aborts immediately to the reset values. No partial word is retained, and the next `start` restarts at `FIRST_REG`.
- The address increment is ADDR_W bits wide. No wrap occurs, because the walk terminates at `LAST_REG`.

## Timing
Let E0 be the posedge that samples `start`.
- E0: `rf_re` = 1 and `rf_addr` = `FIRST_REG` take effect.
- E1: `out_valid` rises with the first word.
- With `out_ready` held high:
  - Handshakes occur at E2, E4, …, E(2N).
  - `done` is high in the cycle following E(2N), where N = `LAST_REG - FIRST_REG + 1`.
  - For the defaults, N = 15 and the last handshake is at E30.
- Throughput is one word per 2 cycles. Each cycle of backpressure adds one cycle.
- The RF read value appears on `p0` at the negedge inside the READ cycle and is stable at the following posedge.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `start` = 1 → all outputs 0, state IDLE, no `rf_re` pulse.
- **Full dump:** preload a negedge-read RF model with Ri = 16'h1000+i. Pulse `start` and hold `out_ready` = 1 → 15 words with `out_addr` 1..15 and `out_data` 16'h1001..16'h100F in order. `done` is a single pulse after E30. `rf_re` has exactly 15 one-cycle pulses.
- **Backpressure:** drop `out_ready` for 5 cycles while word R3 is valid → `out_addr` = 3 and `out_data` = 16'h1003 stay stable, `rf_re` = 0 throughout, and no word is skipped or duplicated.
- **Start while busy:** pulse `start` at E5 → ignored, and the sequence is unchanged. Pulse `start` during the `done` cycle → a new dump begins, with `out_valid` and `out_addr` = 1 appearing two cycles later.
- **Reset mid-dump:** assert `rst` after the 4th handshake → the next cycle shows all outputs 0. A new `start` dumps from R1.
- **Single register:** set `FIRST_REG` = `LAST_REG` = 7 with R7 = 16'hBEEF → one word `{7, BEEF}`, handshake at E2, `done` in the following cycle.

Source files
------------

// File: rtl/rf_dump_reader.sv
// rf_dump_reader
//
// Read-side sequencer for the 2-read/1-write block-SRAM register file.
// A start pulse walks registers FIRST_REG..LAST_REG through one RF read
// port and streams each {address, data} pair out over a valid/ready
// handshake. This gives a synthesizable path toward a UART/debug sink.
// The sequencer owns the RF read port only while busy is high.
//
// Ports:
//   clk        system clock; all logic on posedge (RF read data moves on negedge)
//   rst        synchronous active-high reset
//   start      one-cycle dump request, ignored while busy
//   busy       high from the cycle after start is accepted until done
//   done       one-cycle pulse after the last word's handshake
//   rf_addr    RF read address (p0_addr)
//   rf_re      RF read enable (re0), high only during READ cycles
//   rf_data    RF read data (p0)
//   out_valid  output word valid
//   out_ready  sink accepts the word
//   out_addr   register index of the current word
//   out_data   register contents of the current word
module rf_dump_reader #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 16,
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_re,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(LAST_REG);

    logic [1:0] state;

    // Single registered FSM. READ lasts exactly one cycle: the RF presents
    // p0 on the negedge inside it, so rf_data is stable at the closing
    // posedge, which is the only edge where it is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rf_re     <= 1'b0;
            out_valid <= 1'b0;
            rf_addr   <= '0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            // done is a pulse; any branch that finishes a dump re-asserts it
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rf_addr <= FIRST_ADDR;
                        rf_re   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= READ;
                    end
                end
                READ: begin
                    out_data  <= rf_data;
                    out_addr  <= rf_addr;
                    out_valid <= 1'b1;
                    rf_re     <= 1'b0;
                    state     <= SEND;
                end
                SEND: begin
                    // out_valid is always high in SEND, so out_ready alone
                    // marks the handshake; the word holds until it happens
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_addr == LAST_ADDR) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            rf_addr <= rf_addr + 1'b1;
                            rf_re   <= 1'b1;
                            state   <= READ;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    rf_re     <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
